// File: rtl/sdram_pkg.sv
// Shared types and host-port width defaults for the SDRAM frame writer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sdram_pkg;

  localparam int SDRAM_DATA_WIDTH  = 16;
  localparam int SDRAM_HADDR_WIDTH = 23;
  localparam int OVF_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WAIT_DONE
  } sdram_frame_writer_state_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Small synchronous first-word-fall-through FIFO holding pixels awaiting a host write.
// Latency: a word pushed at edge N is visible at head_dat (empty=0) from N+1.
// Backpressure: push is refused when full unless a pop happens the same cycle; clr empties it.
module sdram_wr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// Captures one frame from a non-stallable pixel stream and writes it word-by-word to the SDRAM host port.
// Latency: pixel accepted at edge N can be presented as a write (wr_o) from N+1; one word/cycle sustained.
// Backpressure: none upstream; pixels arriving with a full FIFO are dropped and flagged (overflow_o,
//   plus a saturating ovf_cnt_o when SDRAM_WR_OVF_CNT_EN is defined).
module sdram_frame_writer
  import sdram_pkg::*;
#(
  parameter int                     DATA_WIDTH  = SDRAM_DATA_WIDTH,
  parameter int                     HADDR_WIDTH = SDRAM_HADDR_WIDTH,
  parameter int                     FIFO_DEPTH  = 16,
  parameter int                     FRAME_WORDS = 1228800,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_WIDTH-1:0]  pix_i,
  input  logic                   pix_valid_i,
  output logic                   wr_o,
  output logic                   rd_o,
  output logic [HADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  input  logic                   op_begun_i,
  input  logic                   done_i,
`ifdef SDRAM_WR_OVF_CNT_EN
  output logic [OVF_CNT_WIDTH-1:0] ovf_cnt_o,
`endif
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic                   overflow_o
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);

  sdram_frame_writer_state_t state;
  logic [CNT_W-1:0]       in_cnt;
  logic [HADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]  head_dat;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_clr;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   arm;
  logic                   last_pix;

  assign arm      = (state == ST_IDLE) && start_i;
  assign fifo_clr = arm;
  // A request stays up while anything is buffered; it is retired only when the controller begins it.
  assign pop      = !fifo_empty && op_begun_i;
  assign push     = (state == ST_RUN) && pix_valid_i && (!fifo_full || pop);
  assign drop     = (state == ST_RUN) && pix_valid_i && fifo_full && !pop;
  assign last_pix = (in_cnt == CNT_W'(FRAME_WORDS - 1));

  assign wr_o   = !fifo_empty;
  assign rd_o   = 1'b0;
  assign addr_o = addr_q;
  assign data_o = fifo_empty ? '0 : head_dat;
  assign busy_o = (state != ST_IDLE);

  sdram_wr_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (fifo_clr),
    .push     (push),
    .push_dat (pix_i),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Frame sequencing: count incoming pixels, advance the write address per accepted write,
  // and hand back completion once the controller signals the last operation done.
  // addr_q doubles as BASE_ADDR + wr_idx, wrapping naturally at the host address width;
  // dropped words never advance it, so the stored frame is contiguous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      in_cnt       <= '0;
      addr_q       <= BASE_ADDR;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (pop) addr_q <= addr_q + HADDR_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_RUN;
            in_cnt     <= '0;
            addr_q     <= BASE_ADDR;
            overflow_o <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pix_valid_i) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (drop) overflow_o <= 1'b1;
            if (last_pix) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_i) begin
            frame_done_o <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SDRAM_WR_OVF_CNT_EN
  // Saturating count of words dropped in the current frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || arm) begin
      ovf_cnt_o <= '0;
    end else if (drop && (ovf_cnt_o != '1)) begin
      ovf_cnt_o <= ovf_cnt_o + OVF_CNT_WIDTH'(1);
    end
  end
`endif

endmodule
